// File: rtl/hdc_feature_packer_if.sv
// Stream bundle between the feature source, the packer and the fusion core.
// A beat or frame moves on a rising edge where valid & ready are both high; valid never depends on ready.
interface hdc_feature_packer_if #(
  parameter int NUM_CHANNEL   = 214,
  parameter int CHANNEL_WIDTH = 4,
  parameter int CNT_WIDTH     = 16
) ();
  logic [CHANNEL_WIDTH-1:0]             ch_data;
  logic                                 ch_valid;
  logic                                 ch_last;
  logic                                 ch_ready;
  logic [NUM_CHANNEL*CHANNEL_WIDTH-1:0] features_top;
  logic                                 fout_valid;
  logic                                 fout_ready;
  logic                                 frame_err;
  logic [CNT_WIDTH-1:0]                 frame_count;
  logic                                 dbg_resync;

  modport slave (
    input  ch_data, ch_valid, ch_last, fout_ready,
    output ch_ready, features_top, fout_valid, frame_err, frame_count, dbg_resync
  );

  modport master (
    output ch_data, ch_valid, ch_last, fout_ready,
    input  ch_ready, features_top, fout_valid, frame_err, frame_count, dbg_resync
  );
endinterface

// File: rtl/hdc_feature_packer.sv
// Packs one feature per beat into a full frame, ping-ponging two frame buffers
// so the next frame can stream in while the fusion core holds the current one.
module hdc_feature_packer #(
  parameter int NUM_CHANNEL   = 214,
  parameter int CHANNEL_WIDTH = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  hdc_feature_packer_if.slave   bus
);
  localparam int FW = NUM_CHANNEL * CHANNEL_WIDTH;
  localparam int IW = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CHANNEL - 1);

  typedef enum logic {ST_FILL = 1'b0, ST_RESYNC = 1'b1} state_e;

  state_e               st_q, st_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [FW-1:0]        buf_q [2];
  logic [1:0]           full_q, full_d;
  logic                 head_q;
  logic                 fill_q;
  logic                 ch_ready_q;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 acc, hs, at_last, complete, wr_en;

  assign acc     = bus.ch_valid & ch_ready_q;
  assign at_last = (idx_q == LAST_IDX);
  assign hs      = (|full_q) & bus.fout_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st_q <= ST_FILL;
    else      st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    if (acc) begin
      case (st_q)
        ST_FILL:   if (!bus.ch_last && at_last) st_d = ST_RESYNC;
        ST_RESYNC: if (bus.ch_last) st_d = ST_FILL;
        default:   st_d = ST_FILL;
      endcase
    end
  end

  // Any malformed frame (early or overlong last) just leaves its buffer empty.
  always_comb begin
    wr_en    = 1'b0;
    complete = 1'b0;
    err_d    = 1'b0;
    idx_d    = idx_q;
    if (acc && st_q == ST_FILL) begin
      wr_en = 1'b1;
      if (bus.ch_last && at_last) begin
        complete = 1'b1;
        idx_d    = '0;
      end else if (bus.ch_last || at_last) begin
        err_d = 1'b1;
        idx_d = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  always_comb begin
    full_d = full_q;
    if (hs)       full_d[head_q] = 1'b0;
    if (complete) full_d[fill_q] = 1'b1;
  end

  // Strict A/B alternation keeps the head as the oldest full buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q      <= '0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      full_q     <= '0;
      head_q     <= 1'b0;
      fill_q     <= 1'b0;
      ch_ready_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      idx_q      <= idx_d;
      full_q     <= full_d;
      ch_ready_q <= ~&full_d;
      err_q      <= err_d;
      if (hs)       head_q <= ~head_q;
      if (complete) fill_q <= ~fill_q;
      if (hs)       cnt_q  <= cnt_q + CNT_WIDTH'(1);
      if (wr_en)    buf_q[fill_q][idx_q*CHANNEL_WIDTH +: CHANNEL_WIDTH] <= bus.ch_data;
    end
  end

  assign bus.ch_ready     = ch_ready_q;
  assign bus.features_top = buf_q[head_q];
  assign bus.fout_valid   = |full_q;
  assign bus.frame_err    = err_q;
  assign bus.frame_count  = cnt_q;
  assign bus.dbg_resync   = (st_q == ST_RESYNC);
endmodule

// File: tb/tb_hdc_feature_packer.sv
// Directed bench for hdc_feature_packer with a 4-channel, 4-bit, 2-bit-counter configuration.
module tb_hdc_feature_packer;
  localparam int NC   = 4;
  localparam int CW   = 4;
  localparam int CNTW = 2;
  localparam int FW   = NC * CW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hdc_feature_packer_if #(.NUM_CHANNEL(NC), .CHANNEL_WIDTH(CW), .CNT_WIDTH(CNTW)) bus ();

  hdc_feature_packer #(.NUM_CHANNEL(NC), .CHANNEL_WIDTH(CW), .CNT_WIDTH(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [FW-1:0]   exp_q[$];
  logic [CNTW-1:0] exp_cnt = '0;
  int dlv_cnt = 0;
  int err_cnt = 0;
  logic hold_q = 1'b0;
  logic [FW-1:0] held = '0;
  logic prev_err = 1'b0;

  typedef struct {
    logic [FW-1:0] frame;
    int            nbeats;
    bit            ok;
    logic [FW-1:0] exp_feat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Scoreboard: every delivered frame against exp_q, plus hold stability and single err pulses.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      exp_cnt  = '0;
      hold_q   = 1'b0;
      prev_err = 1'b0;
    end else begin
      if (hold_q) begin
        check("hold_valid", 32'(bus.fout_valid), 32'd1);
        check("hold_data", 32'(bus.features_top), 32'(held));
      end
      if (bus.fout_valid && bus.fout_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got %0h want none", bus.features_top);
        end else begin
          check("frame_data", 32'(bus.features_top), 32'(exp_q.pop_front()));
        end
        check("frame_count_at_hs", 32'(bus.frame_count), 32'(exp_cnt));
        exp_cnt++;
        dlv_cnt++;
      end
      hold_q = bus.fout_valid & ~bus.fout_ready;
      held   = bus.features_top;
      if (bus.frame_err) begin
        err_cnt++;
        check("err_single_pulse", 32'(prev_err), 32'd0);
      end
      prev_err = bus.frame_err;
    end
  end

  task automatic send_beat(input logic [CW-1:0] d, input logic l);
    int n = 0;
    bus.ch_data  = d;
    bus.ch_valid = 1'b1;
    bus.ch_last  = l;
    while (!bus.ch_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("beat_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.ch_valid = 1'b0;
    bus.ch_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [FW-1:0] f, input int nbeats);
    for (int i = 0; i < nbeats; i++) send_beat(f[i*CW +: CW], i == nbeats - 1);
  endtask

  task automatic wait_dlv(input int target);
    int n = 0;
    while (dlv_cnt < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("deliver_timeout", 32'(dlv_cnt >= target), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    logic [CNTW-1:0] wrap_exp[5];
    logic [FW-1:0] f;
    int base_d;
    int base_e;

    vecs[0] = '{frame: 16'h00BA, nbeats: 2, ok: 1'b0, exp_feat: 16'h0000};
    vecs[1] = '{frame: 16'h8765, nbeats: 4, ok: 1'b1, exp_feat: 16'h8765};
    vecs[2] = '{frame: 16'hFFFF, nbeats: 4, ok: 1'b1, exp_feat: 16'hFFFF};
    vecs[3] = '{frame: 16'h0000, nbeats: 4, ok: 1'b1, exp_feat: 16'h0000};
    vecs[4] = '{frame: 16'h000C, nbeats: 1, ok: 1'b0, exp_feat: 16'h0000};
    vecs[5] = '{frame: 16'h0DEF, nbeats: 3, ok: 1'b0, exp_feat: 16'h0000};
    vecs[6] = '{frame: 16'h5A5A, nbeats: 4, ok: 1'b1, exp_feat: 16'h5A5A};
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

    bus.ch_data    = '0;
    bus.ch_valid   = 1'b0;
    bus.ch_last    = 1'b0;
    bus.fout_ready = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_ch_ready", 32'(bus.ch_ready), 32'd0);
    check("rst_fout_valid", 32'(bus.fout_valid), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check("rst_frame_count", 32'(bus.frame_count), 32'd0);
    check("rst_features", 32'(bus.features_top), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", 32'(bus.ch_ready), 32'd1);

    // Basic frame with one-cycle latency
    bus.fout_ready = 1'b1;
    base_d = dlv_cnt;
    exp_q.push_back(16'h4321);
    send_frame(16'h4321, 4);
    check("basic_valid", 32'(bus.fout_valid), 32'd1);
    check("basic_data", 32'(bus.features_top), 32'h4321);
    wait_dlv(base_d + 1);
    check("basic_count", 32'(bus.frame_count), 32'd1);

    // Table: good and early-last frames
    for (int v = 0; v < 7; v++) begin
      base_d = dlv_cnt;
      base_e = err_cnt;
      if (vecs[v].ok) exp_q.push_back(vecs[v].exp_feat);
      send_frame(vecs[v].frame, vecs[v].nbeats);
      repeat (4) @(posedge clk);
      #1;
      check($sformatf("vec%0d_delivered", v), 32'(dlv_cnt - base_d), vecs[v].ok ? 32'd1 : 32'd0);
      check($sformatf("vec%0d_err", v), 32'(err_cnt - base_e), vecs[v].ok ? 32'd0 : 32'd1);
    end

    // Backpressure: two buffers fill, ready drops, release gives back-to-back frames
    bus.fout_ready = 1'b0;
    base_d = dlv_cnt;
    exp_q.push_back(16'h3210);
    exp_q.push_back(16'h7654);
    exp_q.push_back(16'hBA98);
    send_frame(16'h3210, 4);
    send_frame(16'h7654, 4);
    check("bp_ready_low", 32'(bus.ch_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("bp_hold_valid", 32'(bus.fout_valid), 32'd1);
    check("bp_hold_data", 32'(bus.features_top), 32'h3210);
    bus.fout_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_no_bubble_valid", 32'(bus.fout_valid), 32'd1);
    check("bp_no_bubble_data", 32'(bus.features_top), 32'h7654);
    send_frame(16'hBA98, 4);
    wait_dlv(base_d + 3);
    check("bp_delivered", 32'(dlv_cnt - base_d), 32'd3);

    // Overlong frame: error after 4th beat, rest discarded until ch_last
    base_d = dlv_cnt;
    base_e = err_cnt;
    for (int i = 0; i < 6; i++) begin
      send_beat(CW'(i + 1), i == 5);
      if (i == 3) check("overlong_err_pulse", 32'(bus.frame_err), 32'd1);
      if (i == 4) check("overlong_resync", 32'(bus.dbg_resync), 32'd1);
    end
    repeat (3) @(posedge clk);
    #1;
    check("overlong_err_count", 32'(err_cnt - base_e), 32'd1);
    check("overlong_no_output", 32'(dlv_cnt - base_d), 32'd0);
    exp_q.push_back(16'h9ABC);
    send_frame(16'h9ABC, 4);
    wait_dlv(base_d + 1);
    check("after_overlong_delivered", 32'(dlv_cnt - base_d), 32'd1);

    // Reset with a full frame pending and a partial one in flight
    bus.fout_ready = 1'b0;
    exp_q.push_back(16'h2468);
    send_frame(16'h2468, 4);
    send_beat(4'h1, 1'b0);
    send_beat(4'h2, 1'b0);
    check("pre_rst_valid", 32'(bus.fout_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_fout_valid", 32'(bus.fout_valid), 32'd0);
    check("midrst_frame_count", 32'(bus.frame_count), 32'd0);
    check("midrst_ch_ready", 32'(bus.ch_ready), 32'd0);
    check("midrst_features", 32'(bus.features_top), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready_back", 32'(bus.ch_ready), 32'd1);

    // Fresh frames after reset; the 2-bit counter wraps 1,2,3,0,1
    bus.fout_ready = 1'b1;
    f = 16'h1357;
    for (int k = 0; k < 5; k++) begin
      base_d = dlv_cnt;
      exp_q.push_back(f);
      send_frame(f, 4);
      wait_dlv(base_d + 1);
      check($sformatf("wrap_count%0d", k), 32'(bus.frame_count), 32'(wrap_exp[k]));
      f = f + 16'h1111;
    end

    repeat (2) @(posedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hdc_feature_packer.md
Name: hdc_feature_packer

Overview:
- Upstream feeder of hdc_sensor_fusion.
- Accepts one channel feature per beat on a narrow valid/ready stream and assembles a full frame of NUM_CHANNEL features into the wide features_top word.
- Presents each assembled frame to the fusion core with a fin_valid/fin_ready-compatible handshake (fout_valid/fout_ready).
- Ping-pong buffering lets the next frame stream in while the core holds off acceptance of the current one.

Parameters:
- NUM_CHANNEL, 214: features per frame; equals TOTAL_NUM_CHANNEL.
- CHANNEL_WIDTH, 4: bits per feature; equals CHANNEL_WIDTH.
- CNT_WIDTH, 16: width of frame_count.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-low.
- ch_data  in  CHANNEL_WIDTH  feature value for the current channel.
- ch_valid  in  1  ch_data/ch_last valid.
- ch_last  in  1  marks the final channel of a frame.
- ch_ready  out  1  packer can accept a beat.
- features_top  out  NUM_CHANNEL*CHANNEL_WIDTH  assembled frame; channel i at bits [i*CHANNEL_WIDTH +: CHANNEL_WIDTH].
- fout_valid  out  1  features_top holds a complete frame.
- fout_ready  in  1  downstream (fusion core fin_ready) accepts the frame.
- frame_err  out  1  one-cycle pulse when a malformed frame is dropped.
- frame_count  out  CNT_WIDTH  count of frames delivered (fout handshakes); wraps modulo 2^CNT_WIDTH.

Behaviour:
Reset values (rst low, asynchronous):
- ch_ready=0, fout_valid=0, frame_err=0, frame_count=0, features_top=0.
- Both buffers empty; fill index=0; FSM in FILL.
- ch_ready rises to 1 on the first clock edge after rst deasserts.

Beat acceptance and frame assembly:
- Beat accepted when ch_valid & ch_ready at the rising edge.
- Accepted beat writes ch_data into the fill buffer at slot idx; idx then increments.
- Fill buffer = whichever of the two buffers is not full; when both are empty, fill A first.
- Buffers alternate strictly A, B, A, ...; frames are delivered in arrival order.

FSM:
- FILL:
  - Beat with ch_last=1 and idx==NUM_CHANNEL-1: buffer marked full, idx<=0, stay in FILL.
  - Beat with ch_last=1 and idx<NUM_CHANNEL-1: early end. Frame dropped, buffer stays empty, frame_err pulses on the next cycle, idx<=0, stay in FILL.
  - Beat with ch_last=0 and idx==NUM_CHANNEL-1: overlong frame. Frame dropped, frame_err pulses, idx<=0, go to RESYNC.
- RESYNC:
  - ch_ready=1 (subject to the buffer-availability rule below); accepted beats are discarded.
  - A beat with ch_last=1 returns the FSM to FILL with idx=0.
  - Only one frame_err pulse per dropped frame.

Flow control:
- ch_ready = !(both buffers full). Purely registered; no combinational path from fout_ready.
- A buffer freed by a fout handshake raises ch_ready on the following cycle.

Output:
- features_top is driven from a registered head buffer.
- fout_valid=1 whenever at least one full buffer exists.
- Latency: fout_valid asserts 1 cycle after the accepting edge of a completing ch_last beat, when the output was idle.
- While fout_valid=1 and fout_ready=0, features_top and fout_valid hold stable.
- On a fout handshake:
  - Head buffer freed and frame_count increments.
  - If the other buffer is full, it becomes head and fout_valid stays 1 next cycle (back-to-back frames, no bubble).

Simultaneous and boundary cases:
- Frame completion and fout handshake in the same cycle are both honoured. The completing buffer becomes head next cycle if the old head was freed.
- A fout handshake while both buffers are full: the freed buffer is available for filling from the next cycle.
- fout_ready with fout_valid=0 is ignored.
- NUM_CHANNEL=1: every beat must carry ch_last=1; a beat with ch_last=0 triggers RESYNC.
- Reset asserted mid-frame or mid-handshake: all partial and full frames discarded; outputs return to reset values immediately (asynchronous).

Test Plan:
(Bench parameters: NUM_CHANNEL=4, CHANNEL_WIDTH=4.)
- Basic frame: send 0x1,0x2,0x3,0x4 with ch_last on the 4th beat, fout_ready=1 -> fout_valid high 1 cycle after the 4th beat; features_top=16'h4321; frame_count=1.
- Backpressure: fout_ready=0, stream 3 frames back-to-back -> ch_ready drops after frame 2 completes; frame 1 holds stable. Release fout_ready -> frames 1,2,3 delivered in order with no valid gap between 1 and 2; frame_count=3.
- Early last: beats 0xA,0xB with ch_last on the 2nd beat -> frame_err single pulse, no fout_valid. The next valid frame 0x5,0x6,0x7,0x8 is delivered as 16'h8765.
- Overlong frame: 6 beats with ch_last on the 6th -> frame_err pulses once after the 4th beat; beats 5-6 discarded; no output. The following good frame is delivered correctly.
- Reset mid-stream: rst low after 2 beats and with a full frame pending -> fout_valid=0 and frame_count=0 immediately. After rst high, ch_ready=1 next edge; a fresh frame is delivered correctly.
- Counter wrap with CNT_WIDTH=2: deliver 5 frames -> frame_count sequence 1,2,3,0,1.
